// File: rtl/cpu_clock_control_pkg.sv
// Shared state encoding for the CPU clock controller, also used by
// peripheral_manager to show the current clock mode.
package internal_state;

    typedef enum logic [1:0] {
        CLOCK_HALTED  = 2'd0,
        CLOCK_RUNNING = 2'd1,
        CLOCK_STEP    = 2'd2
    } clock_mode_t;

    localparam int PRESCALER_WIDTH = 33;

    // Ones in bits [rate_select:0]; the pulse fires when all of them are set.
    function automatic logic [PRESCALER_WIDTH-1:0] rate_mask(input logic [4:0] rate_select);
        return (PRESCALER_WIDTH'(2) << rate_select) - PRESCALER_WIDTH'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counting debouncer and rising-edge detect for one
// raw push button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_100mhz,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed
);

    localparam int COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   sync_meta;
    logic                   sync_level;
    logic                   level_prev;
    logic [COUNT_WIDTH-1:0] count;

    // The stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            count      <= '0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
            level_prev <= level;
            if (sync_level == level) begin
                count <= '0;
            end else if (count == COUNT_LAST) begin
                level <= sync_level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign pressed = level & ~level_prev;

endmodule

// File: rtl/cpu_clock_control.sv
// Single-domain CPU clock-enable generator: free-run at a switch-selected
// rate, halt, and single-step from debounced push buttons.
module cpu_clock_control
    import internal_state::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int STEP_COUNT_WIDTH = 16
) (
    input  logic                        clock_100mhz,
    input  logic                        reset,
    input  logic [4:0]                  rate_select,
    input  logic                        run_button,
    input  logic                        step_button,
    output logic                        cpu_clock_enable,
    output logic                        running,
    output clock_mode_t                 mode,
    output logic [STEP_COUNT_WIDTH-1:0] step_count
);

    clock_mode_t                state;
    clock_mode_t                next_state;
    logic                       run_event;
    logic                       step_event;
    logic                       unused_run_level;
    logic                       unused_step_level;
    logic                       pulse_due;
    logic                       enable_next;
    logic [PRESCALER_WIDTH-1:0] prescaler;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) run_debouncer (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .raw          (run_button),
        .level        (unused_run_level),
        .pressed      (run_event)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) step_debouncer (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .raw          (step_button),
        .level        (unused_step_level),
        .pressed      (step_event)
    );

    always_ff @(posedge clock_100mhz) begin
        if (reset) state <= CLOCK_HALTED;
        else       state <= next_state;
    end

    // Run beats step when both land together; a run press during STEP is dropped.
    always_comb begin
        next_state  = state;
        pulse_due   = ((prescaler & rate_mask(rate_select)) == rate_mask(rate_select));
        unique case (state)
            CLOCK_HALTED: begin
                if (run_event)       next_state = CLOCK_RUNNING;
                else if (step_event) next_state = CLOCK_STEP;
            end
            CLOCK_RUNNING: begin
                if (run_event) next_state = CLOCK_HALTED;
            end
            default: next_state = CLOCK_HALTED;
        endcase
        enable_next = ((state == CLOCK_HALTED) && (next_state == CLOCK_STEP)) ||
                      ((state == CLOCK_RUNNING) && pulse_due && !run_event);
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            prescaler        <= '0;
            cpu_clock_enable <= 1'b0;
            running          <= 1'b0;
            step_count       <= '0;
        end else begin
            prescaler        <= ((state == CLOCK_RUNNING) && (next_state == CLOCK_RUNNING)) ?
                                prescaler + 1'b1 : '0;
            cpu_clock_enable <= enable_next;
            running          <= (next_state == CLOCK_RUNNING);
            if (cpu_clock_enable) step_count <= step_count + 1'b1;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_cpu_clock_control.sv
// Scoreboard bench for cpu_clock_control: expected enable-pulse cycles are
// queued when buttons are driven and matched as pulses appear.
module tb_cpu_clock_control;
    import internal_state::*;

    localparam int DEBOUNCE = 4;
    localparam int COUNT_W  = 8;

    logic               clock_100mhz = 1'b0;
    logic               reset        = 1'b1;
    logic [4:0]         rate_select  = 5'd0;
    logic               run_button   = 1'b0;
    logic               step_button  = 1'b0;
    logic               cpu_clock_enable;
    logic               running;
    clock_mode_t        mode;
    logic [COUNT_W-1:0] step_count;

    int cyc         = 0;
    int assertCount = 0;
    int failCount   = 0;
    int expQ[$];

    cpu_clock_control #(
        .DEBOUNCE_CYCLES  (DEBOUNCE),
        .STEP_COUNT_WIDTH (COUNT_W)
    ) dut (
        .clock_100mhz     (clock_100mhz),
        .reset            (reset),
        .rate_select      (rate_select),
        .run_button       (run_button),
        .step_button      (step_button),
        .cpu_clock_enable (cpu_clock_enable),
        .running          (running),
        .mode             (mode),
        .step_count       (step_count)
    );

    always #5 clock_100mhz = ~clock_100mhz;

    always @(posedge clock_100mhz) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run_level, input logic step_level);
        run_button  = run_level;
        step_button = step_level;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clock_100mhz);
            #1;
        end
    endtask

    // Every enable pulse must match the oldest queued expectation.
    always @(negedge clock_100mhz) begin
        if (!reset && cpu_clock_enable) begin
            if (expQ.size() != 0) checkOutput("enable_cycle", cyc, expQ.pop_front());
            else                  checkOutput("unexpected_enable", cyc, -1);
        end
    end

    initial begin
        int n;
        int m;
        int p;
        int r;

        waitUntil(3);
        checkOutput("reset_mode", longint'(mode), longint'(CLOCK_HALTED));
        checkOutput("reset_running", running, 0);
        checkOutput("reset_enable", cpu_clock_enable, 0);
        checkOutput("reset_count", step_count, 0);
        reset = 1'b0;

        waitUntil(103);
        $display("[TB] idle done");
        checkOutput("idle_mode", longint'(mode), longint'(CLOCK_HALTED));
        checkOutput("idle_count", step_count, 0);

        for (int i = 0; i < 3; i++) begin
            n = cyc;
            expQ.push_back(n + 7);
            applyStimulus(1'b0, 1'b1);
            waitUntil(n + 7);
            checkOutput("step_mode_step", longint'(mode), longint'(CLOCK_STEP));
            waitUntil(n + 8);
            checkOutput("step_mode_halted", longint'(mode), longint'(CLOCK_HALTED));
            waitUntil(n + 10);
            applyStimulus(1'b0, 1'b0);
            waitUntil(n + 20);
        end
        checkOutput("step_count_3", step_count, 3);

        $display("[TB] free run at rate 2");
        rate_select = 5'd2;
        n = cyc;
        for (int k = 15; k <= 66; k += 8) expQ.push_back(n + k);
        applyStimulus(1'b1, 1'b0);
        waitUntil(n + 6);
        checkOutput("run_not_yet", running, 0);
        waitUntil(n + 7);
        checkOutput("run_started", running, 1);
        checkOutput("run_mode", longint'(mode), longint'(CLOCK_RUNNING));
        waitUntil(n + 10);
        applyStimulus(1'b0, 1'b0);
        waitUntil(n + 20);
        applyStimulus(1'b1, 1'b0);
        waitUntil(n + 23);
        applyStimulus(1'b0, 1'b0);
        waitUntil(n + 30);
        applyStimulus(1'b0, 1'b1);
        waitUntil(n + 35);
        applyStimulus(1'b0, 1'b0);
        waitUntil(n + 50);
        checkOutput("glitch_mode", longint'(mode), longint'(CLOCK_RUNNING));
        waitUntil(n + 60);
        applyStimulus(1'b1, 1'b0);
        waitUntil(n + 66);
        checkOutput("stop_not_yet", running, 1);
        waitUntil(n + 67);
        checkOutput("stop_running", running, 0);
        checkOutput("stop_mode", longint'(mode), longint'(CLOCK_HALTED));
        waitUntil(n + 70);
        applyStimulus(1'b0, 1'b0);
        waitUntil(n + 100);
        checkOutput("run_pending", expQ.size(), 0);
        checkOutput("run_count", step_count, 10);

        $display("[TB] simultaneous run+step at rate 0");
        rate_select = 5'd0;
        m = cyc;
        for (int j = 0; j < 245; j++) expQ.push_back(m + 9 + 2 * j);
        applyStimulus(1'b1, 1'b1);
        waitUntil(m + 7);
        checkOutput("simul_mode", longint'(mode), longint'(CLOCK_RUNNING));
        waitUntil(m + 8);
        checkOutput("simul_mode_next", longint'(mode), longint'(CLOCK_RUNNING));
        waitUntil(m + 10);
        applyStimulus(1'b0, 1'b0);
        waitUntil(m + 492);
        applyStimulus(1'b1, 1'b0);
        waitUntil(m + 498);
        checkOutput("fast_stop_not_yet", running, 1);
        waitUntil(m + 499);
        checkOutput("fast_stop_mode", longint'(mode), longint'(CLOCK_HALTED));
        waitUntil(m + 502);
        applyStimulus(1'b0, 1'b0);
        waitUntil(m + 520);
        checkOutput("fast_pending", expQ.size(), 0);
        checkOutput("count_all_ones", step_count, 255);

        p = cyc;
        expQ.push_back(p + 7);
        applyStimulus(1'b0, 1'b1);
        waitUntil(p + 8);
        checkOutput("count_wrap", step_count, 0);
        waitUntil(p + 10);
        applyStimulus(1'b0, 1'b0);
        waitUntil(p + 20);

        $display("[TB] reset while running");
        rate_select = 5'd2;
        r = cyc;
        expQ.push_back(r + 15);
        applyStimulus(1'b1, 1'b0);
        waitUntil(r + 7);
        checkOutput("pre_reset_running", running, 1);
        waitUntil(r + 20);
        reset = 1'b1;
        waitUntil(r + 21);
        checkOutput("mid_reset_mode", longint'(mode), longint'(CLOCK_HALTED));
        checkOutput("mid_reset_running", running, 0);
        checkOutput("mid_reset_enable", cpu_clock_enable, 0);
        checkOutput("mid_reset_count", step_count, 0);
        reset = 1'b0;
        expQ.push_back(r + 36);
        expQ.push_back(r + 44);
        waitUntil(r + 27);
        checkOutput("held_not_yet", running, 0);
        waitUntil(r + 28);
        checkOutput("held_run_event", running, 1);
        waitUntil(r + 30);
        applyStimulus(1'b0, 1'b0);
        waitUntil(r + 40);
        applyStimulus(1'b1, 1'b0);
        waitUntil(r + 47);
        checkOutput("final_stop_mode", longint'(mode), longint'(CLOCK_HALTED));
        waitUntil(r + 50);
        applyStimulus(1'b0, 1'b0);
        waitUntil(r + 70);
        checkOutput("final_pending", expQ.size(), 0);
        checkOutput("final_count", step_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
